mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Round-robin arbiter that multiplexes memory requests from NUM_CORES cores onto the single read/write port of the shared spsram instance.
- Sits directly upstream of spsram. It registers the winning request onto the SRAM port and returns an acknowledge, with read data, to the requesting core.
- Sustains one SRAM access per cycle when two or more cores are requesting.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- DATA_WIDTH, 16, data word width; matches spsram.
- ADDR_WIDTH, 12, word address width; matches spsram (SIZE=4096).

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_CORES  per-core request; held high until that core's ack.
- we  in  NUM_CORES  per-core write enable; qualified by req.
- addr  in  NUM_CORES*ADDR_WIDTH  per-core address; core i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_CORES*DATA_WIDTH  per-core write data; same packing.
- ack  out  NUM_CORES  one-cycle pulse per completed access; at most one bit set.
- rdata  out  DATA_WIDTH  read data; valid only while some ack bit is high.
- sram_addr  out  ADDR_WIDTH  to spsram addr_a; registered.
- sram_we  out  1  to spsram we_a; registered.
- sram_wdata  out  DATA_WIDTH  to spsram data_a; registered.
- sram_q  in  DATA_WIDTH  from spsram q_a; 1-cycle registered read data.

Behaviour:
- Reset (asynchronous, active-high):
  - sram_addr=0, sram_we=0, sram_wdata=0, ack=0.
  - Priority pointer=0, issue_valid=0, in-flight mask=0.
  - All accesses in flight are discarded; no ack is generated for them after reset releases.
- Eligibility at edge E: core i is eligible when req[i]=1 and in_flight[i]=0. in_flight[i] is set when core i is granted at E-1.
- Arbitration: among eligible cores, grant the first found scanning upward from the pointer index, wrapping modulo NUM_CORES. After a grant to core g, the pointer becomes (g+1) mod NUM_CORES. The pointer is unchanged when there is no grant.
- Issue at edge E0:
  - sram_addr, sram_we and sram_wdata load the granted core's addr, we and wdata.
  - issue_valid=1 and issue_id=g are recorded.
  - With no grant: sram_we=0; sram_addr and sram_wdata hold their values (a harmless re-read); issue_valid=0.
- SRAM access at edge E1: spsram captures the access. On a write, q_a returns the written data.
- Completion: ack[issue_id] is registered high on E1, for the cycle E1..E2. rdata = sram_q combinationally during that cycle, for both reads and writes.
- Latency: request sampled at E0 → ack and rdata valid in the cycle after E1, i.e. 2 edges.
- Back-to-back from one core:
  - The core may keep req high in the ack cycle with a new addr/we/wdata; this counts as a new request, eligible at E2.
  - Maximum rate per core is one access every 2 cycles. Aggregate rate is 1 per cycle with ≥2 active cores.
- Fairness: each continuously requesting core waits at most NUM_CORES-1 grants.
- Requests dropped before ack are illegal: behaviour is undefined and flagged by an assertion in simulation.
- Simultaneous requests from all cores are served in pointer order with no idle cycles.

Decomposition:
- Package pasc_mem_pkg: MEM_ADDR_WIDTH, MEM_DATA_WIDTH, and the core-ID width $clog2(NUM_CORES).
- Sub-module rr_arbiter(NUM_CORES):
  - Inputs: request vector, advance.
  - Outputs: one-hot grant, grant index.
  - Owns the priority pointer register.
- mem_arbiter owns the mux, the issue/in-flight registers and the ack generation.

Test Plan:
- Reset with spsram preloaded: no req for 10 cycles → ack=0, sram_we=0 throughout. Reset asserted mid-access → no ack after release.
- Core 1 writes addr 0x005 data 0xBEEF, then reads 0x005 → ack[1] two edges after each request; read rdata=0xBEEF; write-ack rdata=0xBEEF.
- All 4 cores request reads of addresses 0x10..0x13 (SRAM data = address) at once → acks in order 0,1,2,3 on consecutive cycles, each rdata equals its address.
- Cores 0 and 2 hold req continuously for 20 cycles → grants alternate 0,2,0,2, one ack every cycle, no core starved.
- Core 3 alone issues back-to-back reads → ack every 2nd cycle; no duplicate grant while the access is in flight.
- Pointer wrap: pointer at 3 with req from cores 0 and 3 → core 3 granted first, then core 0.

Source files
------------

// File: rtl/pasc_mem_pkg.sv
// Shared constants and helpers for the shared-SRAM arbitration slice.
// Widths default to the spsram geometry (4096 x 16).
package pasc_mem_pkg;

  localparam int MEM_ADDR_WIDTH = 12;
  localparam int MEM_DATA_WIDTH = 16;

  function automatic int core_id_width(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

  // Increment an index, wrapping to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request bus plus the spsram port driven by the arbiter.
// slave = arbiter view, master = cores/SRAM environment view.
interface mem_arbiter_if
  import pasc_mem_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

  logic [NUM_CORES-1:0]            req;
  logic [NUM_CORES-1:0]            we;
  logic [NUM_CORES*ADDR_WIDTH-1:0] addr;
  logic [NUM_CORES*DATA_WIDTH-1:0] wdata;
  logic [NUM_CORES-1:0]            ack;
  logic [DATA_WIDTH-1:0]           rdata;

  logic [ADDR_WIDTH-1:0]           sram_addr;
  logic                            sram_we;
  logic [DATA_WIDTH-1:0]           sram_wdata;
  logic [DATA_WIDTH-1:0]           sram_q;

  modport slave (
    input  req, we, addr, wdata, sram_q,
    output ack, rdata, sram_addr, sram_we, sram_wdata
  );

  modport master (
    output req, we, addr, wdata, sram_q,
    input  ack, rdata, sram_addr, sram_we, sram_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping, and moves the pointer just past the winner when advanced.
module rr_arbiter
  import pasc_mem_pkg::*;
#(
  parameter  int NUM_CORES = 4,
  localparam int ID_W      = core_id_width(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req_i,
  input  logic                 advance_i,
  output logic [NUM_CORES-1:0] grant_o,
  output logic [ID_W-1:0]      grant_idx_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!found && req_i[cand[ID_W-1:0]]) begin
        found                     = 1'b1;
        grant_o[cand[ID_W-1:0]]   = 1'b1;
        grant_idx_o               = cand[ID_W-1:0];
      end
    end
  end

  // Pointer only moves on an actual grant, so idle cycles keep priority.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) ptr_d = ID_W'(wrap_inc(int'(grant_idx_o), NUM_CORES));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multiplexes NUM_CORES request ports onto one registered spsram port and
// returns a one-cycle ack with the SRAM read data to the winning core.
module mem_arbiter
  import pasc_mem_pkg::*;
#(
  parameter  int NUM_CORES  = 4,
  parameter  int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter  int ADDR_WIDTH = MEM_ADDR_WIDTH,
  localparam int ID_W       = core_id_width(NUM_CORES)
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  logic [NUM_CORES-1:0]  eligible;
  logic [NUM_CORES-1:0]  grant;
  logic [ID_W-1:0]       grant_idx;

  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  sram_we_q, sram_we_d;
  logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
  logic                  issue_vld_q, issue_vld_d;
  logic [ID_W-1:0]       issue_id_q, issue_id_d;
  logic [NUM_CORES-1:0]  in_flight_q, in_flight_d;
  logic [NUM_CORES-1:0]  ack_q, ack_d;

  // A core granted last edge still holds req until its ack; mask it out.
  assign eligible = bus.req & ~in_flight_q;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .req_i       (eligible),
    .advance_i   (|eligible),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_we_d    = 1'b0;
    issue_vld_d  = 1'b0;
    issue_id_d   = issue_id_q;
    in_flight_d  = grant;
    ack_d        = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        sram_addr_d  = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sram_wdata_d = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sram_we_d    = bus.we[i];
      end
    end
    if (|grant) begin
      issue_vld_d = 1'b1;
      issue_id_d  = grant_idx;
    end
    if (issue_vld_q) ack_d[issue_id_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_wdata_q <= '0;
      issue_vld_q  <= 1'b0;
      issue_id_q   <= '0;
      in_flight_q  <= '0;
      ack_q        <= '0;
    end else begin
      sram_addr_q  <= sram_addr_d;
      sram_we_q    <= sram_we_d;
      sram_wdata_q <= sram_wdata_d;
      issue_vld_q  <= issue_vld_d;
      issue_id_q   <= issue_id_d;
      in_flight_q  <= in_flight_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_wdata = sram_wdata_q;
  assign bus.ack        = ack_q;
  // spsram already registers q_a, so read data passes straight through.
  assign bus.rdata      = bus.sram_q;

`ifndef SYNTHESIS
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_req_hold
    a_req_held: assert property (@(posedge clk) disable iff (reset)
      eligible[gi] |=> bus.req[gi]);
  end
  a_ack_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.ack));
`endif

endmodule
